// File: rtl/reg_file_onehot_pkg.sv
// Shared sizing constants for the register file and its paired write-enable decoder.
package reg_file_onehot_pkg;

    localparam int unsigned WIDTH_DEF  = 32;
    localparam int unsigned ADDR_DEF   = 4;
    localparam int unsigned NREG_DEF   = 1 << ADDR_DEF;
    localparam int unsigned PC_IDX     = NREG_DEF - 1;
    localparam int unsigned ECNT_W_DEF = 8;

endpackage

// File: rtl/reg_file_onehot_check.sv
// Classifies a write-enable vector as zero, one-hot or multi-hot and encodes the set bit.
module onehot_check
    import reg_file_onehot_pkg::*;
#(
    parameter  int unsigned ADDR = ADDR_DEF,
    localparam int unsigned NREG = 1 << ADDR
) (
    input  logic [NREG-1:0] vec,
    output logic            is_zero,
    output logic            is_onehot,
    output logic            is_multi,
    output logic [ADDR-1:0] idx
);

    localparam int unsigned CNT_W = ADDR + 1;

    logic [CNT_W-1:0] cnt;

    // Unknown bits propagate into cnt, so an X/Z enable never looks one-hot.
    always_comb begin
        cnt = '0;
        idx = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            cnt = cnt + CNT_W'(vec[i]);
            if (vec[i]) idx = idx | ADDR'(i);
        end
    end

    assign is_zero   = (vec == '0);
    assign is_onehot = (cnt == CNT_W'(1));
    assign is_multi  = (cnt >= CNT_W'(2));

endmodule

// File: rtl/reg_file_onehot.sv
// Architectural register file: one-hot writes, two combinational read ports,
// top index reads PC+8, multi-hot write enables are rejected and counted.
module reg_file_onehot
    import reg_file_onehot_pkg::*;
#(
    parameter  int unsigned WIDTH  = WIDTH_DEF,
    parameter  int unsigned ADDR   = ADDR_DEF,
    parameter  int unsigned BYPASS = 0,
    parameter  int unsigned ECNT_W = ECNT_W_DEF,
    localparam int unsigned NREG   = 1 << ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREG-1:0]   we_onehot,
    input  logic [WIDTH-1:0]  wd,
    input  logic [ADDR-1:0]   ra1,
    input  logic [ADDR-1:0]   ra2,
    input  logic [WIDTH-1:0]  r15_in,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    output logic              wen_err,
    output logic [ECNT_W-1:0] err_cnt
);

    localparam int unsigned LAST = NREG - 1;

    typedef logic [WIDTH-1:0] regs_t [NREG-1];

    regs_t             regs_q, regs_d;
    logic              wen_err_q, wen_err_d;
    logic [ECNT_W-1:0] err_cnt_q, err_cnt_d;

    logic              is_zero_c, is_onehot_c, is_multi_c;
    logic [ADDR-1:0]   idx_c;
    logic              valid_c, wr_en_c;

    onehot_check #(.ADDR(ADDR)) u_check (
        .vec       (we_onehot),
        .is_zero   (is_zero_c),
        .is_onehot (is_onehot_c),
        .is_multi  (is_multi_c),
        .idx       (idx_c)
    );

    assign valid_c = !is_multi_c && (is_zero_c || is_onehot_c);
    assign wr_en_c = valid_c && is_onehot_c && (idx_c != ADDR'(LAST));

    // Next state: valid enables write and clear the flag; anything else is an error.
    always_comb begin
        regs_d    = regs_q;
        wen_err_d = 1'b0;
        err_cnt_d = err_cnt_q;
        if (valid_c) begin
            wen_err_d = 1'b0;
        end else begin
            wen_err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ECNT_W'(1);
        end
        for (int i = 0; i < int'(LAST); i++) begin
            if (wr_en_c && (idx_c == ADDR'(i))) regs_d[i] = wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LAST); i++) regs_q[i] <= '0;
            wen_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            regs_q    <= regs_d;
            wen_err_q <= wen_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    function automatic logic [WIDTH-1:0] rd_sel(input logic [ADDR-1:0] ra, input regs_t regs,
                                                input logic hit);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < int'(LAST); i++) begin
            if (ra == ADDR'(i)) v = regs[i];
        end
        if (hit) v = wd;
        if (ra == ADDR'(LAST)) v = r15_in;
        return v;
    endfunction

    // Forwarding is suppressed while reset is asserted so reads clear immediately.
    logic byp1_c, byp2_c;
    assign byp1_c = (BYPASS != 0) && rst_n && wr_en_c && (ra1 == idx_c);
    assign byp2_c = (BYPASS != 0) && rst_n && wr_en_c && (ra2 == idx_c);

    assign rd1     = rd_sel(ra1, regs_q, byp1_c);
    assign rd2     = rd_sel(ra2, regs_q, byp2_c);
    assign wen_err = wen_err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_reg_file_onehot.sv
// Bench for reg_file_onehot: directed table, corner sequences and random stimulus
// against a behavioural model, on a non-bypass and a bypass instance.
module tb_reg_file_onehot;

    logic        clk;
    logic        rst_n;
    logic [15:0] we;
    logic [31:0] wd;
    logic [3:0]  ra1, ra2;
    logic [31:0] r15;
    logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;
    logic        err0, err1;
    logic [7:0]  cnt0, cnt1;

    reg_file_onehot #(.WIDTH(32), .ADDR(4), .BYPASS(0), .ECNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .we_onehot(we), .wd(wd), .ra1(ra1), .ra2(ra2),
        .r15_in(r15), .rd1(rd1_0), .rd2(rd2_0), .wen_err(err0), .err_cnt(cnt0)
    );

    reg_file_onehot #(.WIDTH(32), .ADDR(4), .BYPASS(1), .ECNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .we_onehot(we), .wd(wd), .ra1(ra1), .ra2(ra2),
        .r15_in(r15), .rd1(rd1_1), .rd2(rd2_1), .wen_err(err1), .err_cnt(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state.
    logic [31:0] mregs [16];
    bit          merr;
    int          mcnt;
    int          n_pass, n_total;

    typedef struct {
        logic [15:0] we;
        logic [31:0] wd;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_err;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [31:0] exp_rd(input logic [3:0] ra, input bit byp);
        if (ra == 4'd15) return r15;
        if (byp && rst_n && $countones(we) == 1 && !we[15] && we[ra]) return wd;
        return mregs[ra];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        merr = 1'b0;
        mcnt = 0;
    endtask

    task automatic model_edge();
        int pc;
        pc = $countones(we);
        if (!rst_n) begin
            model_reset();
        end else if (pc >= 2) begin
            merr = 1'b1;
            if (mcnt < 255) mcnt++;
        end else begin
            merr = 1'b0;
            for (int k = 0; k < 15; k++) if (pc == 1 && we[k]) mregs[k] = wd;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk_reads();
        chk("rd1_nobyp", rd1_0, exp_rd(ra1, 1'b0));
        chk("rd2_nobyp", rd2_0, exp_rd(ra2, 1'b0));
        chk("rd1_byp",   rd1_1, exp_rd(ra1, 1'b1));
        chk("rd2_byp",   rd2_1, exp_rd(ra2, 1'b1));
    endtask

    task automatic chk_regs();
        chk("wen_err_nobyp", 32'(err0), 32'(merr));
        chk("wen_err_byp",   32'(err1), 32'(merr));
        chk("err_cnt_nobyp", 32'(cnt0), 32'(mcnt));
        chk("err_cnt_byp",   32'(cnt1), 32'(mcnt));
    endtask

    function automatic logic [15:0] rand_multi();
        logic [15:0] v;
        do v = 16'($urandom); while ($countones(v) < 2);
        return v;
    endfunction

    initial begin
        n_pass = 0; n_total = 0;
        rst_n = 1'b1; we = '0; wd = '0; ra1 = '0; ra2 = '0; r15 = 32'h0000_0108;
        model_reset();

        tbl[0] = '{16'h0008, 32'hDEAD_BEEF, 4'd3,  4'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 8'd0};
        tbl[1] = '{16'h8000, 32'h0000_1234, 4'd15, 4'd3, 32'h0000_0108, 32'hDEAD_BEEF, 1'b0, 8'd0};
        tbl[2] = '{16'h0011, 32'hFFFF_FFFF, 4'd0,  4'd4, 32'h0000_0000, 32'h0000_0000, 1'b1, 8'd1};
        tbl[3] = '{16'h0000, 32'h0000_0000, 4'd3,  4'd0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 8'd1};
        tbl[4] = '{16'h0001, 32'h0000_A5A5, 4'd0,  4'd4, 32'h0000_A5A5, 32'h0000_0000, 1'b0, 8'd1};
        tbl[5] = '{16'h0010, 32'h0000_0077, 4'd4,  4'd0, 32'h0000_0077, 32'h0000_A5A5, 1'b0, 8'd1};

        #2 rst_n = 1'b0;
        cyc();
        cyc();
        #2 rst_n = 1'b1;

        // Reset state on every index.
        for (int i = 0; i < 16; i++) begin
            ra1 = 4'(i);
            ra2 = 4'(15 - i);
            #1;
            chk("reset_rd1", rd1_0, (i == 15) ? 32'h0000_0108 : 32'h0);
            chk("reset_rd2", rd2_1, (i == 0)  ? 32'h0000_0108 : 32'h0);
        end
        chk("reset_wen_err", 32'(err0), 32'h0);
        chk("reset_err_cnt", 32'(cnt0), 32'h0);

        // Directed table.
        for (int r = 0; r < 6; r++) begin
            we = tbl[r].we; wd = tbl[r].wd; ra1 = tbl[r].ra1; ra2 = tbl[r].ra2;
            #1;
            if (r == 0) begin
                chk("same_cycle_nobyp", rd2_0, 32'h0);
                chk("same_cycle_byp",   rd2_1, 32'hDEAD_BEEF);
            end
            chk_reads();
            cyc();
            chk("tbl_rd1", rd1_0, tbl[r].e_rd1);
            chk("tbl_rd2", rd2_0, tbl[r].e_rd2);
            chk("tbl_rd1_byp", rd1_1, tbl[r].e_rd1);
            chk("tbl_err", 32'(err0), 32'(tbl[r].e_err));
            chk("tbl_cnt", 32'(cnt1), 32'(tbl[r].e_cnt));
            chk_regs();
        end

        // Saturation of the error counter.
        for (int n = 0; n < 300; n++) begin
            we = rand_multi(); wd = $urandom; ra1 = 4'($urandom); ra2 = 4'($urandom);
            #1;
            chk_reads();
            cyc();
            chk("sat_wen_err", 32'(err0), 32'h1);
        end
        chk("sat_cnt_nobyp", 32'(cnt0), 32'd255);
        chk("sat_cnt_byp",   32'(cnt1), 32'd255);
        chk("sat_r0_kept", rd2_0, exp_rd(ra2, 1'b0));

        // Mid-cycle reset while a write to R2 is pending.
        we = 16'h0004; wd = 32'h99; ra1 = 4'd2; ra2 = 4'd3;
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_wen_err", 32'(err0), 32'h0);
        chk("rst_err_cnt", 32'(cnt1), 32'h0);
        chk("rst_r2",      rd1_0, 32'h0);
        chk("rst_r3",      rd2_0, 32'h0);
        chk("rst_r2_byp",  rd1_1, 32'h0);
        cyc();
        chk("rst_hold_r2", rd1_0, 32'h0);
        #2 rst_n = 1'b1;
        wd = 32'h55;
        #1;
        cyc();
        chk("post_rst_r2", rd1_0, 32'h55);
        chk("post_rst_r2_byp", rd1_1, 32'h55);
        chk_regs();

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0:       we = '0;
                1, 2:    we = 16'(1) << $urandom_range(0, 15);
                default: we = rand_multi();
            endcase
            wd = $urandom; ra1 = 4'($urandom); ra2 = 4'($urandom);
            if ($urandom_range(0, 7) == 0) r15 = $urandom;
            #1;
            chk_reads();
            cyc();
            chk_regs();
            chk_reads();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
